dpram_portb_arbiter: RTL and testbench
======================================

# dpram_portb_arbiter

Shares port B of the boot/program dual-port block RAM between two requesters. Master 0 is the CPU data bus; master 1 is the debug/ROM loader that rewrites program memory at run time. Port A stays dedicated to instruction fetch and is not touched by this block. The arbiter issues at most one access per cycle, returns read data with the RAM's fixed one-cycle latency, and supports locked loader bursts.

## Interface
- ADDR, 12: RAM word-address width
- DATA, 32: RAM data width
- LOCK_MAX, 256: maximum consecutive locked cycles before a forced release
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  access request; held with its command until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR  word address
- m0_wdata / m1_wdata  in  DATA  write data
- m1_lock  in  1  loader requests exclusive ownership
- m0_ack / m1_ack  out  1  command accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid (registered, one cycle after ack of a read)
- m0_rdata / m1_rdata  out  DATA  read data; equals b_read, qualified by rvalid
- b_ce, b_we  out  1  RAM port B enable / write
- b_addr  out  ADDR  RAM port B address
- b_write  out  DATA  RAM port B write data
- b_read  in  DATA  RAM port B read data, valid the cycle after address issue
- owner  out  1  master granted in the last issued cycle
- locked  out  1  lock FSM is in LOCKED

## Operation
- Grant is combinational each cycle. If one master requests, it wins. If both request, the master not in last_grant wins (round robin).
- The granted master's command drives b_*, with b_ce=1 and b_we=we. Its ack=1 in the same cycle. With no grant, b_ce=0, b_we=0, and b_addr holds the last value.
- Read issued in cycle N: the master's rvalid=1 in cycle N+1, with rdata=b_read. Writes produce no rvalid.
- Back-to-back reads from either master are allowed. rvalid is steered by a registered rd_owner flag.
- Lock FSM states:
  - IDLE: round robin. IDLE→LOCKED when m1 is granted with m1_lock=1.
  - LOCKED: only m1 may be granted. m0 waits, with ack=0.
    - LOCKED→IDLE when m1_lock=0 is sampled.
    - LOCKED→RELEASE when lock_cnt reaches LOCK_MAX-1 and m0_req=1.
  - RELEASE: m0 is granted unconditionally for exactly one access. Then RELEASE→IDLE, with last_grant=0 so that m1 wins the next conflict.
- lock_cnt counts cycles in LOCKED. It clears on entry to LOCKED and saturates at LOCK_MAX-1 when m0 is idle.
- Reset: state=IDLE, last_grant=1 (m0 wins the first conflict), lock_cnt=0, all rvalid=0, owner=0, locked=0. While reset is high, both ack=0 and b_ce=0.

## Timing
- Arbitration latency is 0 cycles: ack is in the request cycle when uncontended.
- Read latency is 1 cycle from ack to rvalid.
- Worst-case m0 wait is 1 cycle unlocked, or LOCK_MAX+1 cycles locked.
- Reset during a read: the pending rvalid is suppressed, and the RAM contents written so far are retained.
- Simultaneous m1_lock deassert and LOCK_MAX expiry: IDLE takes priority over RELEASE.
- A write and a read to the same address in consecutive cycles: the read returns the new data.

## Configuration
- DPRAM_ARB_LOCK_EN defined: lock FSM, lock_cnt and the locked output are active as described above.
- Not defined: m1_lock is ignored, locked is tied to 0, and arbitration is pure round robin.

## Structure
- Shared package dpram_arb_pkg holds:
  - the lock state encoding (IDLE, LOCKED, RELEASE);
  - the master ids MST_CPU=0 and MST_LDR=1;
  - the default LOCK_MAX.
- One sub-module, rr_pick2, is natural: a two-input round-robin pick with last_grant register and override inputs, used by the top level.

## Test plan
- Reset, then m0 read of addr 0x010 (RAM preloaded 0x0BADF00D): m0_ack in the request cycle; m0_rvalid and m0_rdata=0x0BADF00D one cycle later.
- m0 and m1 both request continuously: grants alternate m0, m1, m0, …, with exactly one b_ce per cycle.
- m1 writes 0xDEADBEEF to 0x123, then m0 reads 0x123 the next cycle: m0_rdata=0xDEADBEEF.
- Lock enabled: m1 holds m1_lock for 10 cycles while m0 requests. m0_ack=0 throughout; m0 is granted in the cycle after m1_lock falls.
- Lock enabled, LOCK_MAX=4, m1_lock held high and m0 requesting: m0 gets exactly one ack after 4 locked cycles, then the FSM returns to IDLE.
- Reset asserted in the cycle after an m1 read ack: m1_rvalid stays 0, locked=0, and owner=0.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// Shared definitions for the port-B arbiter: lock states, master ids, default lock limit.
package dpram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        RELEASE = 2'd2
    } lock_state_e;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_LDR = 1'b1;

    localparam int LOCK_MAX_DEF = 256;

endpackage

// File: rtl/dpram_portb_arbiter_if.sv
// One requester's command/response bundle on the shared RAM port B.
interface dpram_portb_arbiter_if #(
    parameter int ADDR = 12,
    parameter int DATA = 32
);
    logic            req;
    logic            we;
    logic            lock;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] wdata;
    logic            ack;
    logic            rvalid;
    logic [DATA-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input ack, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/dpram_portb_arbiter_rr_pick2.sv
// Two-input round-robin pick with per-input masks; last_grant starts at the loader so the CPU wins first.
module rr_pick2
    import dpram_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    input  logic mask0,
    input  logic mask1,
    output logic gnt0,
    output logic gnt1
);

    logic last_grant;
    logic r0;
    logic r1;

    assign r0 = en & req0 & ~mask0;
    assign r1 = en & req1 & ~mask1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (r0 && r1) begin
            // Conflict goes to whoever did not win last time.
            if (last_grant == MST_LDR) gnt0 = 1'b1;
            else                       gnt1 = 1'b1;
        end else begin
            gnt0 = r0;
            gnt1 = r1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= MST_LDR;
        end else if (gnt0) begin
            last_grant <= MST_CPU;
        end else if (gnt1) begin
            last_grant <= MST_LDR;
        end
    end

endmodule

// File: rtl/dpram_portb_arbiter.sv
// Port-B arbiter between CPU (m0) and loader (m1) with 1-cycle read return.
// Optional loader lock FSM enabled by defining DPRAM_ARB_LOCK_EN.
module dpram_portb_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int ADDR     = 12,
    parameter int DATA     = 32,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    dpram_portb_arbiter_if.slave  m0,
    dpram_portb_arbiter_if.slave  m1,
    output logic                  b_ce,
    output logic                  b_we,
    output logic [ADDR-1:0]       b_addr,
    output logic [DATA-1:0]       b_write,
    input  logic [DATA-1:0]       b_read,
    output logic                  owner,
    output logic                  locked
);

    logic            gnt0;
    logic            gnt1;
    logic            any_gnt;
    logic            mask0;
    logic            mask1;
    logic            arb_en;
    logic [ADDR-1:0] addr_sel;
    logic [ADDR-1:0] addr_hold_p0;
    logic            rd_vld_p0;
    logic            rd_owner_p0;
    logic            owner_p0;

    assign arb_en = ~reset;

    rr_pick2 u_pick (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req0  (m0.req),
        .req1  (m1.req),
        .mask0 (mask0),
        .mask1 (mask1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

`ifdef DPRAM_ARB_LOCK_EN
    localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX - 1);

    lock_state_e   state;
    logic [CW-1:0] lock_cnt;
    logic          locked_p0;

    assign mask0  = (state == LOCKED);
    assign mask1  = (state == RELEASE);
    assign locked = locked_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            locked_p0 <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt1 && m1.lock) begin
                        state     <= LOCKED;
                        lock_cnt  <= '0;
                        locked_p0 <= 1'b1;
                    end
                end
                LOCKED: begin
                    // Lock drop wins over a simultaneous expiry.
                    if (!m1.lock) begin
                        state     <= IDLE;
                        locked_p0 <= 1'b0;
                    end else if (lock_cnt == CNT_MAX && m0.req) begin
                        state     <= RELEASE;
                        locked_p0 <= 1'b0;
                    end else if (lock_cnt != CNT_MAX) begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (gnt0) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    locked_p0 <= 1'b0;
                end
            endcase
        end
    end
`else
    assign mask0  = 1'b0;
    assign mask1  = 1'b0;
    assign locked = 1'b0;
`endif

    assign any_gnt = gnt0 | gnt1;
    assign addr_sel = gnt1 ? m1.addr : m0.addr;

    assign m0.ack  = gnt0;
    assign m1.ack  = gnt1;
    assign b_ce    = any_gnt;
    assign b_we    = any_gnt & (gnt1 ? m1.we : m0.we);
    assign b_addr  = any_gnt ? addr_sel : addr_hold_p0;
    assign b_write = gnt1 ? m1.wdata : m0.wdata;

    // ---- issue -> return stage boundary ----
    always_ff @(posedge clk) begin
        if (any_gnt) addr_hold_p0 <= addr_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p0   <= 1'b0;
            rd_owner_p0 <= MST_CPU;
            owner_p0    <= MST_CPU;
        end else begin
            rd_vld_p0 <= any_gnt & ~b_we;
            if (any_gnt) begin
                rd_owner_p0 <= gnt1;
                owner_p0    <= gnt1;
            end
        end
    end

    // Reset also kills a read return already in flight.
    assign m0.rvalid = rd_vld_p0 & (rd_owner_p0 == MST_CPU) & ~reset;
    assign m1.rvalid = rd_vld_p0 & (rd_owner_p0 == MST_LDR) & ~reset;
    assign m0.rdata  = b_read;
    assign m1.rdata  = b_read;
    assign owner     = owner_p0;

endmodule

// File: tb/tb_dpram_portb_arbiter.sv
// Directed bench for dpram_portb_arbiter with a behavioural port-B RAM.
module tb_dpram_portb_arbiter;

    localparam int ADDR = 12;
    localparam int DATA = 32;
    localparam int TB_LOCK_MAX = 12;

    logic            clk;
    logic            reset;
    logic            b_ce;
    logic            b_we;
    logic [ADDR-1:0] b_addr;
    logic [DATA-1:0] b_write;
    logic [DATA-1:0] b_read;
    logic            owner;
    logic            locked;

    logic [DATA-1:0] mem [0:(1<<ADDR)-1];

    int n_vec;
    int n_err;

    dpram_portb_arbiter_if #(.ADDR(ADDR), .DATA(DATA)) m0_if ();
    dpram_portb_arbiter_if #(.ADDR(ADDR), .DATA(DATA)) m1_if ();

    dpram_portb_arbiter #(.ADDR(ADDR), .DATA(DATA), .LOCK_MAX(TB_LOCK_MAX)) dut (
        .clk     (clk),
        .reset   (reset),
        .m0      (m0_if),
        .m1      (m1_if),
        .b_ce    (b_ce),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_write (b_write),
        .b_read  (b_read),
        .owner   (owner),
        .locked  (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b_ce) begin
            if (b_we) mem[b_addr] <= b_write;
            else      b_read <= mem[b_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [ADDR-1:0] addr, input logic [DATA-1:0] wd);
        m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wd;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic lock, input logic [ADDR-1:0] addr,
                            input logic [DATA-1:0] wd);
        m1_if.req = req; m1_if.we = we; m1_if.lock = lock; m1_if.addr = addr; m1_if.wdata = wd;
    endtask

    initial begin
        logic exp1;
        logic prev1;
        int   hits;

        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < (1 << ADDR); i++) mem[i] = '0;
        mem[12'h010] = 32'h0BADF00D;
        mem[12'h020] = 32'h12345678;
        b_read = '0;
        m0_if.lock = 1'b0;

        // Reset with both masters requesting: nothing may be issued.
        reset = 1'b1;
        drive_m0(1'b1, 1'b0, 12'h010, '0);
        drive_m1(1'b1, 1'b0, 1'b0, 12'h020, '0);
        probe();
        check_val("rst_ack0", m0_if.ack, 0);
        check_val("rst_ack1", m1_if.ack, 0);
        check_val("rst_bce", b_ce, 0);
        next_cyc();
        reset = 1'b0;
        drive_m0(1'b0, 1'b0, '0, '0);
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
        probe();
        check_val("rst_owner", owner, 0);
        check_val("rst_locked", locked, 0);
        check_val("rst_rv0", m0_if.rvalid, 0);
        check_val("rst_rv1", m1_if.rvalid, 0);
        next_cyc();

        // Continuous contention: m0, m1, m0, ... with read data steered.
        drive_m0(1'b1, 1'b0, 12'h010, '0);
        drive_m1(1'b1, 1'b0, 1'b0, 12'h020, '0);
        prev1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp1 = (i % 2 == 1);
            probe();
            check_val("rr_ack0", m0_if.ack, !exp1);
            check_val("rr_ack1", m1_if.ack, exp1);
            check_val("rr_bce", b_ce, 1);
            check_val("rr_baddr", b_addr, exp1 ? 12'h020 : 12'h010);
            if (i > 0) begin
                check_val("rr_rv0", m0_if.rvalid, !prev1);
                check_val("rr_rv1", m1_if.rvalid, prev1);
                check_val("rr_rdata", b_read, prev1 ? 32'h12345678 : 32'h0BADF00D);
            end
            prev1 = exp1;
            next_cyc();
        end
        drive_m0(1'b0, 1'b0, '0, '0);
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
        probe();
        check_val("rr_last_rv1", m1_if.rvalid, 1);
        check_val("rr_last_rdata", m1_if.rdata, 32'h12345678);
        check_val("idle_bce", b_ce, 0);
        next_cyc();

        // m0 read of preloaded word, uncontended.
        drive_m0(1'b1, 1'b0, 12'h010, '0);
        probe();
        check_val("rd_ack0", m0_if.ack, 1);
        check_val("rd_bwe", b_we, 0);
        next_cyc();
        drive_m0(1'b0, 1'b0, '0, '0);
        probe();
        check_val("rd_rv0", m0_if.rvalid, 1);
        check_val("rd_rdata0", m0_if.rdata, 32'h0BADF00D);
        check_val("rd_rv1", m1_if.rvalid, 0);
        next_cyc();

        // m1 write, then m0 reads the same address next cycle.
        drive_m1(1'b1, 1'b1, 1'b0, 12'h123, 32'hDEADBEEF);
        probe();
        check_val("wr_ack1", m1_if.ack, 1);
        check_val("wr_bwe", b_we, 1);
        check_val("wr_baddr", b_addr, 12'h123);
        check_val("wr_bwrite", b_write, 32'hDEADBEEF);
        next_cyc();
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
        drive_m0(1'b1, 1'b0, 12'h123, '0);
        probe();
        check_val("raw_ack0", m0_if.ack, 1);
        check_val("wr_no_rv1", m1_if.rvalid, 0);
        next_cyc();
        drive_m0(1'b0, 1'b0, '0, '0);
        probe();
        check_val("raw_rv0", m0_if.rvalid, 1);
        check_val("raw_rdata0", m0_if.rdata, 32'hDEADBEEF);
        check_val("hold_bce", b_ce, 0);
        check_val("hold_baddr", b_addr, 12'h123);
        next_cyc();

`ifdef DPRAM_ARB_LOCK_EN
        // Loader lock held 10 cycles; m0 waits until the cycle after it drops.
        drive_m1(1'b1, 1'b0, 1'b1, 12'h020, '0);
        probe();
        check_val("l1_ack1", m1_if.ack, 1);
        next_cyc();
        drive_m0(1'b1, 1'b0, 12'h010, '0);
        for (int i = 1; i < 10; i++) begin
            probe();
            check_val("l1_ack0", m0_if.ack, 0);
            check_val("l1_locked", locked, 1);
            next_cyc();
        end
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
        probe();
        check_val("l1_drop_ack0", m0_if.ack, 0);
        next_cyc();
        probe();
        check_val("l1_after_ack0", m0_if.ack, 1);
        check_val("l1_after_locked", locked, 0);
        next_cyc();
        drive_m0(1'b0, 1'b0, '0, '0);

        // Lock held past expiry: exactly one forced m0 access, then m1 wins.
        drive_m1(1'b1, 1'b0, 1'b1, 12'h020, '0);
        probe();
        check_val("l2_ack1", m1_if.ack, 1);
        next_cyc();
        drive_m0(1'b1, 1'b0, 12'h010, '0);
        hits = 0;
        for (int i = 1; i <= TB_LOCK_MAX; i++) begin
            probe();
            if (m0_if.ack) hits++;
            check_val("l2_locked", locked, 1);
            next_cyc();
        end
        check_val("l2_wait_hits", hits, 0);
        probe();
        check_val("l2_rel_ack0", m0_if.ack, 1);
        check_val("l2_rel_ack1", m1_if.ack, 0);
        check_val("l2_rel_locked", locked, 0);
        next_cyc();
        probe();
        check_val("l2_idle_ack1", m1_if.ack, 1);
        check_val("l2_idle_ack0", m0_if.ack, 0);
        check_val("l2_idle_locked", locked, 0);
        next_cyc();
        drive_m0(1'b0, 1'b0, '0, '0);
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
        probe();
        check_val("l2_relock", locked, 1);
        next_cyc();
        probe();
        check_val("l2_unlock", locked, 0);
        next_cyc();
`else
        // Without the lock feature m1_lock is ignored: pure alternation.
        drive_m0(1'b1, 1'b0, 12'h010, '0);
        drive_m1(1'b1, 1'b0, 1'b1, 12'h020, '0);
        for (int i = 0; i < 4; i++) begin
            exp1 = (i % 2 == 0);
            probe();
            check_val("nl_ack1", m1_if.ack, exp1);
            check_val("nl_ack0", m0_if.ack, !exp1);
            check_val("nl_locked", locked, 0);
            next_cyc();
        end
        drive_m0(1'b0, 1'b0, '0, '0);
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
        probe();
        next_cyc();
`endif

        // Reset in the cycle after an m1 read ack suppresses its rvalid.
        drive_m1(1'b1, 1'b0, 1'b0, 12'h020, '0);
        probe();
        check_val("rr_m1_ack", m1_if.ack, 1);
        next_cyc();
        drive_m1(1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        probe();
        check_val("rdrst_rv1", m1_if.rvalid, 0);
        next_cyc();
        probe();
        check_val("rdrst_rv1_b", m1_if.rvalid, 0);
        check_val("rdrst_owner", owner, 0);
        check_val("rdrst_locked", locked, 0);
        next_cyc();
        reset = 1'b0;

        // RAM contents survive reset.
        drive_m0(1'b1, 1'b0, 12'h123, '0);
        probe();
        check_val("ret_ack0", m0_if.ack, 1);
        next_cyc();
        drive_m0(1'b0, 1'b0, '0, '0);
        probe();
        check_val("ret_rv0", m0_if.rvalid, 1);
        check_val("ret_rdata0", m0_if.rdata, 32'hDEADBEEF);
        next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
